// File: rtl/state_lookup_app3.sv
// state_lookup_app3: third stateful app, downstream of the DNS state app.
// Counts packets per 64-bit host-pair key in a small associative table and
// clears the output-port field of the action once a key exceeds a threshold.
// A small input FIFO absorbs back-to-back app_done_in strobes.
// Optional build macro: STATE_APP3_STATS_EN adds stat_hits/stat_misses/stat_drops.

`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH 32
`endif
`ifndef OPENFLOW_ENTRY_SRC_PORT_WIDTH
`define OPENFLOW_ENTRY_SRC_PORT_WIDTH 16
`endif

module state_lookup_app3 #(
  parameter int unsigned KEY_WIDTH                     = 64,
  parameter int unsigned TABLE_SIZE                    = 8,
  parameter int unsigned CNT_WIDTH                     = 16,
  parameter int unsigned FIFO_DEPTH_BITS               = 2,
  parameter logic [1:0]  APP_ID                        = 2'b11,
  parameter logic [1:0]  NEXT_APP                      = 2'b00,
  parameter int unsigned OPENFLOW_ACTION_WIDTH         = `OPENFLOW_ACTION_WIDTH,
  parameter int unsigned OPENFLOW_ENTRY_SRC_PORT_WIDTH = `OPENFLOW_ENTRY_SRC_PORT_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     app_done_in,
  input  logic [OPENFLOW_ACTION_WIDTH-1:0]         action_in,
  input  logic [1:0]                               next_app_in,
  input  logic [KEY_WIDTH-1:0]                     match_field_in,
  input  logic [OPENFLOW_ENTRY_SRC_PORT_WIDTH-1:0] flow_entry_src_port_in,
  input  logic [CNT_WIDTH-1:0]                     threshold,
  input  logic                                     table_flush,
  output logic                                     app_done,
  output logic [OPENFLOW_ACTION_WIDTH-1:0]         action_out,
  output logic [1:0]                               next_app,
  output logic [KEY_WIDTH-1:0]                     match_field_out,
  output logic [OPENFLOW_ENTRY_SRC_PORT_WIDTH-1:0] flow_entry_src_port_out,
  output logic                                     fifo_overflow
`ifdef STATE_APP3_STATS_EN
  ,
  output logic [31:0]                              stat_hits,
  output logic [31:0]                              stat_misses,
  output logic [31:0]                              stat_drops
`endif
);

  localparam int unsigned ACT_W = OPENFLOW_ACTION_WIDTH;
  localparam int unsigned SRC_W = OPENFLOW_ENTRY_SRC_PORT_WIDTH;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned IW    = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
  // Bits of the action holding the output port; cleared on a drop.
  localparam logic [ACT_W-1:0] PORT_MASK = ACT_W'(16'hFFFF);

  typedef struct packed {
    logic [ACT_W-1:0]     action;
    logic [1:0]           next_app;
    logic [KEY_WIDTH-1:0] key;
    logic [SRC_W-1:0]     src;
  } fifo_ent_t;

  typedef enum logic [1:0] {IDLE, PASS, COMPARE, UPDATE} state_t;

  // ---------------- input FIFO ----------------
  fifo_ent_t                  fifo_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                       full, empty, push, pop;
  fifo_ent_t                  fifo_wr, fifo_rd;

  assign full    = (cnt_q == (FIFO_DEPTH_BITS+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push    = app_done_in && (!full || pop);
  assign fifo_rd = fifo_q[rd_ptr_q];
  assign fifo_wr = '{action: action_in, next_app: next_app_in,
                     key: match_field_in, src: flow_entry_src_port_in};
  assign fifo_overflow = !reset && app_done_in && full && !pop;

  // Occupancy tracks pushes minus pops.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= fifo_wr;
  end

  // ---------------- FSM ----------------
  state_t state_q, state_d;
  logic   emit;

  // Next-state: pop when idle, route to lookup or straight pass-through.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = (fifo_rd.next_app == APP_ID) ? COMPARE : PASS;
        end
      end
      PASS: begin
        emit    = 1'b1;
        state_d = IDLE;
      end
      COMPARE: state_d = UPDATE;
      UPDATE: begin
        emit    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- hold registers ----------------
  logic [ACT_W-1:0]     hold_act_q;
  logic [KEY_WIDTH-1:0] hold_key_q;
  logic [SRC_W-1:0]     hold_src_q;

  // Capture the popped packet for the duration of its processing.
  always_ff @(posedge clk) begin
    if (pop) begin
      hold_act_q <= fifo_rd.action;
      hold_key_q <= fifo_rd.key;
      hold_src_q <= fifo_rd.src;
    end
  end

  // ---------------- associative table ----------------
  logic [TABLE_SIZE-1:0] tbl_vld_q;
  logic [KEY_WIDTH-1:0]  tbl_key_q [TABLE_SIZE];
  logic [CNT_WIDTH-1:0]  tbl_cnt_q [TABLE_SIZE];
  logic [IW-1:0]         victim_q;
  logic                  lk_hit, hit_q;
  logic [IW-1:0]         lk_idx, idx_q;

  // Parallel match; scanning downward leaves the lowest matching index.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (tbl_vld_q[i] && (tbl_key_q[i] == hold_key_q)) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
    end
  end

  // Register the lookup result at the end of COMPARE.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      idx_q <= '0;
    end else if (state_q == COMPARE) begin
      hit_q <= lk_hit;
      idx_q <= lk_idx;
    end
  end

  logic [CNT_WIDTH-1:0] cur_cnt, new_cnt;
  logic                 drop;
  logic [ACT_W-1:0]     upd_action;

  // Counter update value and the drop decision for the UPDATE cycle.
  always_comb begin
    cur_cnt = tbl_cnt_q[idx_q];
    if (!hit_q)        new_cnt = CNT_WIDTH'(1);
    else if (&cur_cnt) new_cnt = cur_cnt;
    else               new_cnt = cur_cnt + 1'b1;
    drop       = (threshold != '0) && (new_cnt > threshold);
    upd_action = drop ? (hold_act_q & ~PORT_MASK) : hold_act_q;
  end

  // Valid bits and replacement pointer; flush wins over an UPDATE write.
  always_ff @(posedge clk) begin
    if (reset || table_flush) begin
      tbl_vld_q <= '0;
      victim_q  <= '0;
    end else if ((state_q == UPDATE) && !hit_q) begin
      tbl_vld_q[victim_q] <= 1'b1;
      victim_q <= (victim_q == IW'(TABLE_SIZE - 1)) ? '0 : victim_q + 1'b1;
    end
  end

  // Entry key/count storage, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (!reset && !table_flush && (state_q == UPDATE)) begin
      if (hit_q) begin
        tbl_cnt_q[idx_q] <= new_cnt;
      end else begin
        tbl_key_q[victim_q] <= hold_key_q;
        tbl_cnt_q[victim_q] <= new_cnt;
      end
    end
  end

  // ---------------- result outputs ----------------
  // Registered result; fields hold until the next emitted packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      app_done                <= 1'b0;
      action_out              <= '0;
      match_field_out         <= '0;
      flow_entry_src_port_out <= '0;
    end else begin
      app_done <= emit;
      if (emit) begin
        action_out              <= (state_q == UPDATE) ? upd_action : hold_act_q;
        match_field_out         <= hold_key_q;
        flow_entry_src_port_out <= hold_src_q;
      end
    end
  end

  assign next_app = NEXT_APP;

`ifdef STATE_APP3_STATS_EN
  logic [31:0] hits_q, misses_q, drops_q;

  // Lookup statistics; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      drops_q  <= '0;
    end else if (state_q == UPDATE) begin
      if (hit_q) hits_q   <= hits_q + 1'b1;
      else       misses_q <= misses_q + 1'b1;
      if (drop)  drops_q  <= drops_q + 1'b1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_drops  = drops_q;
`endif

endmodule

// File: tb/tb_state_lookup_app3.sv
// Directed bench for state_lookup_app3 (8-bit counters so saturation is reachable).

`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH 32
`endif
`ifndef OPENFLOW_ENTRY_SRC_PORT_WIDTH
`define OPENFLOW_ENTRY_SRC_PORT_WIDTH 16
`endif

module tb_state_lookup_app3;
  localparam int KW = 64;
  localparam int CW = 8;
  localparam int AW = `OPENFLOW_ACTION_WIDTH;
  localparam int SW = `OPENFLOW_ENTRY_SRC_PORT_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          app_done_in;
  logic [AW-1:0] action_in;
  logic [1:0]    next_app_in;
  logic [KW-1:0] match_field_in;
  logic [SW-1:0] src_in;
  logic [CW-1:0] threshold;
  logic          table_flush;
  logic          app_done;
  logic [AW-1:0] action_out;
  logic [1:0]    next_app;
  logic [KW-1:0] match_field_out;
  logic [SW-1:0] src_out;
  logic          fifo_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  state_lookup_app3 #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .app_done_in(app_done_in), .action_in(action_in),
    .next_app_in(next_app_in), .match_field_in(match_field_in),
    .flow_entry_src_port_in(src_in), .threshold(threshold), .table_flush(table_flush),
    .app_done(app_done), .action_out(action_out), .next_app(next_app),
    .match_field_out(match_field_out), .flow_entry_src_port_out(src_out),
    .fifo_overflow(fifo_overflow)
  );

  function automatic logic [SW-1:0] src_of(input logic [KW-1:0] k);
    return SW'(k + 64'd7);
  endfunction

  function automatic logic [AW-1:0] dropped(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    r[15:0] = 16'h0;
    return r;
  endfunction

  // One packet in, wait (bounded) for its result; lat = edges after the input edge.
  task automatic send(input logic [KW-1:0] k, input logic [AW-1:0] a, input logic [1:0] na,
                      output logic got, output int lat, output logic [AW-1:0] a_o,
                      output logic [KW-1:0] k_o, output logic [SW-1:0] s_o);
    @(posedge clk); #1;
    app_done_in = 1'b1; action_in = a; next_app_in = na; match_field_in = k; src_in = src_of(k);
    @(posedge clk); #1;
    app_done_in = 1'b0;
    got = 1'b0; lat = -1; a_o = '0; k_o = '0; s_o = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (app_done) begin
        got = 1'b1; lat = n; a_o = action_out; k_o = match_field_out; s_o = src_out;
        break;
      end
    end
  endtask

  task automatic flush;
    @(posedge clk); #1 table_flush = 1'b1;
    @(posedge clk); #1 table_flush = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    reset = 1'b1; app_done_in = 1'b0; action_in = '0; next_app_in = '0;
    match_field_in = '0; src_in = '0; threshold = '0; table_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({app_done, action_out, match_field_out, src_out, fifo_overflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got done=%b act=%h key=%h src=%h ovf=%b, want all 0",
                         app_done, action_out, match_field_out, src_out, fifo_overflow);
    end
    n_checks++;
    if (next_app !== 2'b00) begin
      n_fail++; $display("FAIL reset_next_app: got %b want 00", next_app);
    end
    @(posedge clk); #1 reset = 1'b0;
    // Reset while a packet is being processed must discard it.
    @(posedge clk); #1;
    app_done_in = 1'b1; action_in = 32'hDEAD_0001; next_app_in = 2'b01; match_field_in = 64'h99;
    @(posedge clk); #1 app_done_in = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (app_done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_midop_discard: got %0d results want 0", seen);
    end
  endtask

  task automatic test_pass;
    logic got; int lat; logic [AW-1:0] a; logic [KW-1:0] k; logic [SW-1:0] s;
    threshold = 8'd1;
    send(64'hA5A5_0000_1111_2222, 32'h1234_0005, 2'b01, got, lat, a, k, s);
    n_checks++;
    if (!got || lat !== 2) begin
      n_fail++; $display("FAIL pass_latency: got done=%b lat=%0d want lat=2", got, lat);
    end
    n_checks++;
    if (a !== 32'h1234_0005 || k !== 64'hA5A5_0000_1111_2222 || s !== src_of(64'hA5A5_0000_1111_2222)) begin
      n_fail++; $display("FAIL pass_fields: got act=%h key=%h src=%h want 12340005 a5a5000011112222 %h",
                         a, k, s, src_of(64'hA5A5_0000_1111_2222));
    end
    @(negedge clk);
    n_checks++;
    if (app_done !== 1'b0) begin
      n_fail++; $display("FAIL pass_pulse: app_done=%b one cycle later, want 0", app_done);
    end
    // Pass-through must not have created an entry: first lookup is cnt=1.
    send(64'hA5A5_0000_1111_2222, 32'h1234_0005, 2'b11, got, lat, a, k, s);
    n_checks++;
    if (!got || lat !== 3 || a !== 32'h1234_0005) begin
      n_fail++; $display("FAIL lookup_first: got done=%b lat=%0d act=%h want lat=3 act=12340005", got, lat, a);
    end
    send(64'hA5A5_0000_1111_2222, 32'h1234_0005, 2'b11, got, lat, a, k, s);
    n_checks++;
    if (!got || a !== 32'h1234_0000) begin
      n_fail++; $display("FAIL lookup_second_drop: got done=%b act=%h want 12340000", got, a);
    end
  endtask

  task automatic test_threshold;
    logic got; int lat; logic [AW-1:0] a; logic [KW-1:0] k; logic [SW-1:0] s;
    logic [AW-1:0] exp [4];
    exp[0] = 32'hABCD_1234; exp[1] = 32'hABCD_1234; exp[2] = 32'hABCD_0000; exp[3] = 32'hABCD_0000;
    flush();
    threshold = 8'd2;
    for (int i = 0; i < 4; i++) begin
      send(64'h0BAD_F00D_0000_0002, 32'hABCD_1234, 2'b11, got, lat, a, k, s);
      n_checks++;
      if (!got || a !== exp[i]) begin
        n_fail++; $display("FAIL threshold_pkt%0d: got done=%b act=%h want %h", i, got, a, exp[i]);
      end
    end
  endtask

  task automatic test_saturate;
    logic got; int lat; logic [AW-1:0] a; logic [KW-1:0] k; logic [SW-1:0] s;
    logic [AW-1:0] e;
    flush();
    threshold = 8'hFE;
    // Counts 1..255 then stick at 255; only counts above 254 drop.
    for (int i = 1; i <= 260; i++) begin
      send(64'h5A7E_0000_0000_0003, 32'h7777_4321, 2'b11, got, lat, a, k, s);
      e = (i >= 255) ? 32'h7777_0000 : 32'h7777_4321;
      n_checks++;
      if (!got || a !== e) begin
        n_fail++; $display("FAIL saturate_pkt%0d: got done=%b act=%h want %h", i, got, a, e);
      end
    end
    threshold = 8'h00;
    for (int i = 0; i < 3; i++) begin
      send(64'h5A7E_0000_0000_0003, 32'h7777_4321, 2'b11, got, lat, a, k, s);
      n_checks++;
      if (!got || a !== 32'h7777_4321) begin
        n_fail++; $display("FAIL thresh0_pkt%0d: got done=%b act=%h want 77774321", i, got, a);
      end
    end
  endtask

  task automatic test_evict;
    logic got; int lat; logic [AW-1:0] a; logic [KW-1:0] k; logic [SW-1:0] s;
    logic [KW-1:0] base;
    base = 64'h1111_0000_0000_0000;
    flush();
    threshold = 8'd1;
    for (int i = 0; i < 9; i++) begin
      send(base + 64'(i), 32'h0000_00AA, 2'b11, got, lat, a, k, s);
      n_checks++;
      if (!got || a !== 32'h0000_00AA || k !== base + 64'(i)) begin
        n_fail++; $display("FAIL evict_fill%0d: got done=%b act=%h key=%h want 000000aa", i, got, a, k);
      end
    end
    // key0 was evicted by key8: miss, count 1, not dropped.
    send(base, 32'h0000_00AA, 2'b11, got, lat, a, k, s);
    n_checks++;
    if (!got || a !== 32'h0000_00AA) begin
      n_fail++; $display("FAIL evict_key0_miss: got done=%b act=%h want 000000aa", got, a);
    end
    // key2 survived: hit, count 2, dropped.
    send(base + 64'd2, 32'h0000_00AA, 2'b11, got, lat, a, k, s);
    n_checks++;
    if (!got || a !== 32'h0000_0000) begin
      n_fail++; $display("FAIL evict_key2_hit: got done=%b act=%h want 00000000", got, a);
    end
    // key1 was replaced by the re-inserted key0: miss.
    send(base + 64'd1, 32'h0000_00AA, 2'b11, got, lat, a, k, s);
    n_checks++;
    if (!got || a !== 32'h0000_00AA) begin
      n_fail++; $display("FAIL evict_key1_miss: got done=%b act=%h want 000000aa", got, a);
    end
  endtask

  task automatic test_flush_update;
    logic got; int lat; logic [AW-1:0] a; logic [KW-1:0] k; logic [SW-1:0] s;
    flush();
    threshold = 8'd1;
    send(64'hF1F1_0000_0000_0006, 32'h5555_6666, 2'b11, got, lat, a, k, s);
    // Second packet hits (count 2 -> drop) while the flush lands on its UPDATE.
    @(posedge clk); #1;
    app_done_in = 1'b1; action_in = 32'h5555_6666; next_app_in = 2'b11;
    match_field_in = 64'hF1F1_0000_0000_0006; src_in = src_of(64'hF1F1_0000_0000_0006);
    @(posedge clk); #1 app_done_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 table_flush = 1'b1;
    @(posedge clk); #1 table_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (app_done !== 1'b1 || action_out !== 32'h5555_0000) begin
      n_fail++; $display("FAIL flush_update_result: got done=%b act=%h want 1 55550000", app_done, action_out);
    end
    send(64'hF1F1_0000_0000_0006, 32'h5555_6666, 2'b11, got, lat, a, k, s);
    n_checks++;
    if (!got || a !== 32'h5555_6666) begin
      n_fail++; $display("FAIL flush_then_miss: got done=%b act=%h want 55556666", got, a);
    end
  endtask

  task automatic test_back_to_back;
    logic [KW-1:0] keys [16];
    logic [KW-1:0] base;
    logic [KW-1:0] exp_k;
    int nres, novf, ovf_t;
    base = 64'hB2B0_0000_0000_0000;
    nres = 0; novf = 0; ovf_t = -1;
    flush();
    threshold = 8'd0;
    @(posedge clk); #1;
    app_done_in = 1'b1; action_in = 32'h100; next_app_in = 2'b11; match_field_in = base;
    src_in = src_of(base);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (app_done) begin
        if (nres < 16) keys[nres] = match_field_out;
        nres++;
      end
      if (fifo_overflow) begin novf++; ovf_t = t; end
      @(posedge clk); #1;
      if (t + 1 < 8) begin
        action_in = 32'h100 + AW'(t + 1); match_field_in = base + 64'(t + 1);
        src_in = src_of(base + 64'(t + 1));
      end else begin
        app_done_in = 1'b0;
      end
    end
    // Packet 6 arrives while full with no pop; packet 7 arrives on a pop and is kept.
    n_checks++;
    if (novf !== 1 || ovf_t !== 6) begin
      n_fail++; $display("FAIL b2b_overflow: got pulses=%0d at t=%0d want 1 at t=6", novf, ovf_t);
    end
    n_checks++;
    if (nres !== 7) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 7", nres);
    end
    for (int i = 0; i < 7 && i < nres; i++) begin
      exp_k = base + 64'((i < 6) ? i : 7);
      n_checks++;
      if (keys[i] !== exp_k) begin
        n_fail++; $display("FAIL b2b_order%0d: got key=%h want %h", i, keys[i], exp_k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_threshold();
    test_saturate();
    test_evict();
    test_flush_update();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
